mult_cdb_buffer: RTL and testbench
==================================

// Module: mult_cdb_buffer
// PURPOSE
//  Completion buffer directly downstream of the pipelined mult unit. Captures each
//  finished product (result + destination tag) and holds it in a small FIFO until the
//  CDB arbiter grants it. Exposes a credit-style ready to mult issue, so in-flight
//  products never overflow the buffer; the mult pipeline itself never stalls.
// PARAMETERS
//  DEPTH     4   FIFO entries; power of two, >= 2
//  TAG_W     6   destination physical-register tag width
//  XLEN      32  data width (matches DATA)
// PORTS
//  clock          in   1       system clock, all state on posedge
//  reset          in   1       synchronous, active-high
//  squash         in   1       mispredict flush; mult pipeline squashed same cycle
//  mult_issue     in   1       an operation entered mult this cycle
//  buf_ready      out  1       issue permitted this cycle (credit available)
//  mult_done      in   1       mult result valid this cycle
//  mult_result    in   XLEN    product from mult
//  mult_tag       in   TAG_W   destination tag from mult
//  cdb_req        out  1       buffer holds an entry for the CDB
//  cdb_grant      in   1       arbiter accepts the head entry this cycle
//  cdb_result     out  XLEN    head entry data
//  cdb_tag        out  TAG_W   head entry tag
//  overflow_err   out  1       sticky: push while full (protocol violation)
// BEHAVIOUR
//  - State: head/tail ptrs (log2 DEPTH bits, wrap mod DEPTH), count (0..DEPTH),
//    inflight (0..DEPTH) = issued but not yet done.
//  - Reset: ptrs, count, inflight = 0; cdb_req=0; cdb_result=0; cdb_tag=0;
//    overflow_err=0; buf_ready=1.
//  - buf_ready = (count + inflight) < DEPTH, combinational from registered state.
//    Issuing with buf_ready=0 is illegal; the buffer does not check it.
//  - inflight' = inflight + mult_issue - mult_done; both in one cycle -> unchanged.
//  - push = mult_done: write {mult_result, mult_tag} at tail, tail++.
//  - pop = cdb_req & cdb_grant: head++. cdb_grant with cdb_req=0 is ignored.
//  - count' = count + push - pop. Push+pop same cycle is legal at any occupancy,
//    including full (count stays DEPTH) and empty (see macro for the empty case).
//  - Push while count==DEPTH and no pop: entry dropped, ptrs unchanged,
//    overflow_err set; it stays set until reset (squash does not clear it).
//  - cdb_req = (count != 0); cdb_result/cdb_tag = head entry; head values hold
//    stable while cdb_req=1 and cdb_grant=0. When count==0 they read 0.
//  - Latency (macro off): mult_done in cycle N -> cdb_req in cycle N+1.
//  - squash: next cycle ptrs, count, inflight = 0; mult_done/mult_issue/cdb_grant in
//    the squash cycle are ignored. squash has priority over every other event.
//  - reset has priority over squash.
// CONFIGURATION
//  MULT_CDB_BYPASS_EN defined: when count==0 and mult_done, cdb_req=1 in the same
//    cycle with cdb_result/cdb_tag = mult_result/mult_tag. With cdb_grant also 1,
//    nothing is written; otherwise the entry is pushed normally. Latency 0.
//    Still no bypass in a squash cycle.
//  Undefined: no combinational path from mult_* to cdb_*; latency 1 cycle.
// TESTING
//  1. Reset 2 cycles -> cdb_req=0, buf_ready=1, overflow_err=0, cdb_tag=0.
//  2. Single: issue, then done result=0x0000_000C tag=5, grant held 1 -> cdb_req
//     next cycle with 0xC/5 (bypass build: same cycle), then cdb_req=0 next cycle.
//  3. Credit: 4 issues with grant=0 -> buf_ready=0 after the 4th. 4 dones
//     (tags 1..4) -> count=4; grant 4 cycles -> tags out in order 1,2,3,4.
//  4. Full + simultaneous: count=4, done tag=9 with grant=1 -> head popped, tag 9
//     stored, count stays 4, overflow_err=0.
//  5. Overflow: count=4, grant=0, forced done -> overflow_err=1 sticky, FIFO
//     contents unchanged; persists through squash, clears only on reset.
//  6. Squash: 2 entries + 1 inflight, squash with done=1 -> next cycle cdb_req=0,
//     buf_ready=1, nothing pushed; then new done tag=7 -> emitted normally.
//  Also: scoreboard vs reference FIFO model, 1000 random issue/done/grant cycles,
//  both macro settings.

Source files
------------

// File: rtl/mult_cdb_buffer.sv
// Completion buffer between the pipelined multiplier and the CDB arbiter.
// Optional same-cycle bypass of an empty buffer is enabled with `define MULT_CDB_BYPASS_EN.
module mult_cdb_buffer #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6,
  parameter int XLEN  = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             squash,
  input  logic             mult_issue,
  output logic             buf_ready,
  input  logic             mult_done,
  input  logic [XLEN-1:0]  mult_result,
  input  logic [TAG_W-1:0] mult_tag,
  output logic             cdb_req,
  input  logic             cdb_grant,
  output logic [XLEN-1:0]  cdb_result,
  output logic [TAG_W-1:0] cdb_tag,
  output logic             overflow_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W:0]   DEPTH_W = (CNT_W + 1)'(DEPTH);

  logic [XLEN-1:0]  r_mem_data [DEPTH];
  logic [TAG_W-1:0] r_mem_tag  [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_inflight;
  logic             r_overflow;

  logic             w_empty;
  logic             w_full;
  logic             w_bypass;
  logic             w_req;
  logic             w_grant_ok;
  logic             w_byp_taken;
  logic             w_fifo_pop;
  logic             w_push;
  logic             w_drop;
  logic [CNT_W:0]   w_occupancy;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == DEPTH_C);

`ifdef MULT_CDB_BYPASS_EN
  // An empty buffer presents the incoming product directly; squash suppresses it.
  assign w_bypass = w_empty & mult_done & ~squash;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_req       = ~w_empty | w_bypass;
  assign w_grant_ok  = w_req & cdb_grant & ~squash;
  assign w_byp_taken = w_bypass & cdb_grant;
  assign w_fifo_pop  = w_grant_ok & ~w_byp_taken;

  // A full buffer still accepts a product when the head leaves in the same cycle.
  assign w_push = mult_done & ~squash & ~w_byp_taken & (~w_full | w_fifo_pop);
  assign w_drop = mult_done & ~squash & w_full & ~w_fifo_pop;

  assign w_occupancy = {1'b0, r_count} + {1'b0, r_inflight};
  assign buf_ready   = (w_occupancy < DEPTH_W);

  assign cdb_req      = w_req;
  assign overflow_err = r_overflow;

  always_comb begin
    cdb_result = '0;
    cdb_tag    = '0;
    if (w_bypass) begin
      cdb_result = mult_result;
      cdb_tag    = mult_tag;
    end else if (!w_empty) begin
      cdb_result = r_mem_data[r_head];
      cdb_tag    = r_mem_tag[r_head];
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem_data[r_tail] <= mult_result;
      r_mem_tag[r_tail]  <= mult_tag;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_inflight <= '0;
      r_overflow <= 1'b0;
    end else if (squash) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_inflight <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_fifo_pop) begin
        r_head <= r_head + 1'b1;
      end
      if (w_push && !w_fifo_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_fifo_pop) begin
        r_count <= r_count - 1'b1;
      end
      // A completion with nothing outstanding leaves the counter at zero.
      if (mult_issue && !mult_done) begin
        r_inflight <= r_inflight + 1'b1;
      end else if (!mult_issue && mult_done && (r_inflight != '0)) begin
        r_inflight <= r_inflight - 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mult_cdb_buffer.sv
// Directed and random stimulus for mult_cdb_buffer, checked every cycle against a queue model.
module tb_mult_cdb_buffer;

  localparam int DEPTH = 4;
  localparam int TAG_W = 6;
  localparam int XLEN  = 32;
  localparam int EW    = XLEN + TAG_W;

  logic             clock;
  logic             reset;
  logic             squash;
  logic             mult_issue;
  logic             buf_ready;
  logic             mult_done;
  logic [XLEN-1:0]  mult_result;
  logic [TAG_W-1:0] mult_tag;
  logic             cdb_req;
  logic             cdb_grant;
  logic [XLEN-1:0]  cdb_result;
  logic [TAG_W-1:0] cdb_tag;
  logic             overflow_err;

  int vectors;
  int miscompares;
  bit chk_en;

  // Model: queue of {result, tag}, outstanding count, sticky overflow.
  logic [EW-1:0] exp_q[$];
  int            m_inflight;
  bit            m_ovf;

  mult_cdb_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
    .clock        (clock),
    .reset        (reset),
    .squash       (squash),
    .mult_issue   (mult_issue),
    .buf_ready    (buf_ready),
    .mult_done    (mult_done),
    .mult_result  (mult_result),
    .mult_tag     (mult_tag),
    .cdb_req      (cdb_req),
    .cdb_grant    (cdb_grant),
    .cdb_result   (cdb_result),
    .cdb_tag      (cdb_tag),
    .overflow_err (overflow_err)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic bit m_bypass();
`ifdef MULT_CDB_BYPASS_EN
    return (exp_q.size() == 0) && mult_done && !squash;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_req();
    return (exp_q.size() != 0) || m_bypass();
  endfunction

  function automatic logic [EW-1:0] m_head();
    if (m_bypass()) return {mult_result, mult_tag};
    if (exp_q.size() != 0) return exp_q[0];
    return '0;
  endfunction

  function automatic bit m_ready();
    return (exp_q.size() + m_inflight) < DEPTH;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      exp_q.delete();
      m_inflight = 0;
      m_ovf      = 1'b0;
    end else if (squash) begin
      exp_q.delete();
      m_inflight = 0;
    end else begin
      if (!(m_bypass() && cdb_grant)) begin
        if (m_req() && cdb_grant) void'(exp_q.pop_front());
        if (mult_done) begin
          if (exp_q.size() < DEPTH) exp_q.push_back({mult_result, mult_tag});
          else m_ovf = 1'b1;
        end
      end
      if (mult_issue) m_inflight++;
      if (mult_done && m_inflight > 0) m_inflight--;
    end
  end

  // compare process
  always @(negedge clock) begin
    if (chk_en) begin
      logic [EW-1:0] h;
      h = m_head();
      vectors++;
      if (cdb_req !== m_req() || buf_ready !== m_ready() || overflow_err !== m_ovf ||
          cdb_result !== h[EW-1:TAG_W] || cdb_tag !== h[TAG_W-1:0]) begin
        miscompares++;
        $display("FAIL model t=%0t req=%b/%b ready=%b/%b ovf=%b/%b result=%h/%h tag=%0d/%0d (got/exp)",
                 $time, cdb_req, m_req(), buf_ready, m_ready(), overflow_err, m_ovf,
                 cdb_result, h[EW-1:TAG_W], cdb_tag, h[TAG_W-1:0]);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // driver: one cycle of inputs, returning at the following negedge
  task automatic cyc(input bit issue, input bit done, input logic [XLEN-1:0] res,
                     input logic [TAG_W-1:0] tag, input bit grant, input bit sq);
    @(posedge clock);
    #1;
    mult_issue  = issue;
    mult_done   = done;
    mult_result = res;
    mult_tag    = tag;
    cdb_grant   = grant;
    squash      = sq;
    @(negedge clock);
  endtask

  task automatic idle(input bit grant);
    cyc(1'b0, 1'b0, '0, '0, grant, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset = 1'b1; mult_issue = 0; mult_done = 0; cdb_grant = 0; squash = 0;
    mult_result = '0; mult_tag = '0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    vectors = 0; miscompares = 0; chk_en = 0;
    m_inflight = 0; m_ovf = 0;
    reset = 1'b1; squash = 0; mult_issue = 0; mult_done = 0; cdb_grant = 0;
    mult_result = '0; mult_tag = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk_en = 1;
    check("reset_req", 32'(cdb_req), 0);
    check("reset_ready", 32'(buf_ready), 1);
    check("reset_ovf", 32'(overflow_err), 0);
    check("reset_tag", 32'(cdb_tag), 0);

    // single product
    cyc(1, 0, '0, '0, 1, 0);
    cyc(0, 1, 32'h0000_000C, 6'd5, 1, 0);
`ifdef MULT_CDB_BYPASS_EN
    check("single_byp_req", 32'(cdb_req), 1);
    check("single_byp_tag", 32'(cdb_tag), 5);
    idle(1);
    check("single_after_req", 32'(cdb_req), 0);
`else
    check("single_lat_req", 32'(cdb_req), 0);
    idle(1);
    check("single_req", 32'(cdb_req), 1);
    check("single_result", cdb_result, 32'hC);
    check("single_tag", 32'(cdb_tag), 5);
`endif
    idle(1);
    check("single_drain_req", 32'(cdb_req), 0);

    // credit: four issues, then four completions
    for (int i = 0; i < 4; i++) cyc(1, 0, '0, '0, 0, 0);
    cyc(0, 1, 32'h101, 6'd1, 0, 0);
    check("credit_ready0", 32'(buf_ready), 0);
    for (int i = 2; i <= 4; i++) cyc(0, 1, 32'h100 + 32'(i), 6'(i), 0, 0);
    idle(0);
    check("full_ready", 32'(buf_ready), 0);
    check("full_head_tag", 32'(cdb_tag), 1);

    // full with simultaneous push and pop
    cyc(0, 1, 32'h109, 6'd9, 1, 0);
    check("simul_out_tag", 32'(cdb_tag), 1);
    idle(0);
    check("simul_ovf", 32'(overflow_err), 0);
    check("simul_ready", 32'(buf_ready), 0);
    idle(1); check("order_tag2", 32'(cdb_tag), 2);
    idle(1); check("order_tag3", 32'(cdb_tag), 3);
    idle(1); check("order_tag4", 32'(cdb_tag), 4);
    idle(1); check("order_tag9", 32'(cdb_tag), 9);
    check("order_res9", cdb_result, 32'h109);
    idle(0); check("drained_req", 32'(cdb_req), 0);

    // overflow
    for (int i = 10; i <= 13; i++) cyc(0, 1, 32'h200 + 32'(i), 6'(i), 0, 0);
    cyc(0, 1, 32'h214, 6'd20, 0, 0);
    idle(0);
    check("ovf_set", 32'(overflow_err), 1);
    check("ovf_head", 32'(cdb_tag), 10);
    cyc(0, 0, '0, '0, 0, 1);
    idle(0);
    check("ovf_squash_req", 32'(cdb_req), 0);
    check("ovf_sticky", 32'(overflow_err), 1);
    do_reset();
    check("ovf_cleared", 32'(overflow_err), 0);

    // squash with pending entries and one product in flight
    for (int i = 0; i < 3; i++) cyc(1, 0, '0, '0, 0, 0);
    cyc(0, 1, 32'h21, 6'd21, 0, 0);
    cyc(0, 1, 32'h22, 6'd22, 0, 0);
    cyc(0, 1, 32'h23, 6'd23, 1, 1);
    idle(0);
    check("squash_req", 32'(cdb_req), 0);
    check("squash_ready", 32'(buf_ready), 1);
    cyc(1, 0, '0, '0, 0, 0);
    cyc(0, 1, 32'h77, 6'd7, 1, 0);
`ifdef MULT_CDB_BYPASS_EN
    check("post_squash_tag", 32'(cdb_tag), 7);
    idle(1);
`else
    idle(1);
    check("post_squash_tag", 32'(cdb_tag), 7);
`endif
    idle(0);
    check("post_squash_drain", 32'(cdb_req), 0);

    // random traffic; legality decided from the model state
    for (int n = 0; n < 1000; n++) begin
      bit iss, dn, gr, sq;
      @(posedge clock);
      #1;
      iss = m_ready() && ($urandom_range(0, 2) != 0);
      dn  = (m_inflight > 0) && ($urandom_range(0, 2) != 0);
      gr  = ($urandom_range(0, 1) != 0);
      sq  = ($urandom_range(0, 39) == 0);
      mult_issue  = iss;
      mult_done   = dn;
      mult_result = $urandom;
      mult_tag    = 6'($urandom_range(0, 63));
      cdb_grant   = gr;
      squash      = sq;
      @(negedge clock);
    end
    idle(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
